// File: rtl/lru_matrix_tracker_if.sv
// rtl/lru_matrix_tracker_if.sv - operation, response and flush signals of the LRU tracker
interface lru_matrix_tracker_if #(
  parameter int WAYS = 4,
  parameter int SETS = 16
);
  localparam int SET_BITS = $clog2(SETS);
  localparam int WAY_BITS = $clog2(WAYS);

  logic                op_valid;
  logic                op_ready;
  logic [1:0]          op_code;
  logic [SET_BITS-1:0] op_set;
  logic [WAY_BITS-1:0] op_way;
  logic                flush_start;
  logic                rsp_valid;
  logic [SET_BITS-1:0] rsp_set;
  logic [WAY_BITS-1:0] rsp_victim;
  logic                flush_busy;
  logic                flush_done;

  modport master (
    output op_valid, op_code, op_set, op_way, flush_start,
    input  op_ready, rsp_valid, rsp_set, rsp_victim, flush_busy, flush_done
  );

  modport slave (
    input  op_valid, op_code, op_set, op_way, flush_start,
    output op_ready, rsp_valid, rsp_set, rsp_victim, flush_busy, flush_done
  );
endinterface

// File: rtl/lru_matrix_tracker.sv
// rtl/lru_matrix_tracker.sv - per-set pairwise-order LRU store with registered victim and array flush
module lru_matrix_tracker #(
  parameter int WAYS = 4,
  parameter int SETS = 16
) (
  input logic                 clk_i,
  input logic                 rst_i,
  lru_matrix_tracker_if.slave lru_if
);
  localparam int SET_BITS  = $clog2(SETS);
  localparam int WAY_BITS  = $clog2(WAYS);
  localparam int PAIRS     = WAYS * (WAYS - 1) / 2;
  localparam int PIDX_BITS = (PAIRS > 1) ? $clog2(PAIRS) : 1;

  localparam logic [1:0] OP_TOUCH  = 2'b01;
  localparam logic [1:0] OP_DEMOTE = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  typedef enum logic {S_IDLE, S_FLUSH} state_e;

  state_e              state_q, state_d;
  logic [SET_BITS-1:0] flush_idx_q, flush_idx_d;
  logic [PAIRS-1:0]    lru_q [SETS];
  logic [PAIRS-1:0]    lru_d [SETS];
  logic                rsp_valid_q, rsp_valid_d;
  logic [SET_BITS-1:0] rsp_set_q, rsp_set_d;
  logic [WAY_BITS-1:0] rsp_victim_q, rsp_victim_d;
  logic                flush_done_q, flush_done_d;
  logic [PAIRS-1:0]    op_bits;

  // Bit position of pair (i,j), i<j, in i-major order; bit=1 means way i is more recent.
  function automatic logic [PIDX_BITS-1:0] pidx(input int i, input int j);
    return PIDX_BITS'(i * WAYS - (i * (i + 1)) / 2 + (j - i - 1));
  endfunction

  function automatic logic [PAIRS-1:0] apply_op(input logic [PAIRS-1:0] b,
                                                input logic [1:0] code,
                                                input logic [WAY_BITS-1:0] w);
    logic [PAIRS-1:0] r;
    r = b;
    for (int i = 0; i < WAYS; i++) begin
      for (int j = i + 1; j < WAYS; j++) begin
        if (code == OP_CLEAR) begin
          r[pidx(i, j)] = 1'b0;
        end else if (code == OP_TOUCH) begin
          if (i == int'(w)) r[pidx(i, j)] = 1'b1;
          else if (j == int'(w)) r[pidx(i, j)] = 1'b0;
        end else if (code == OP_DEMOTE) begin
          if (i == int'(w)) r[pidx(i, j)] = 1'b0;
          else if (j == int'(w)) r[pidx(i, j)] = 1'b1;
        end
      end
    end
    return r;
  endfunction

  // The victim is older than every other way; lowest index wins should several match.
  function automatic logic [WAY_BITS-1:0] victim_of(input logic [PAIRS-1:0] b);
    logic [WAY_BITS-1:0] v;
    logic                found;
    logic                ok;
    v     = '0;
    found = 1'b0;
    for (int k = 0; k < WAYS; k++) begin
      ok = 1'b1;
      for (int j = k + 1; j < WAYS; j++) if (b[pidx(k, j)]) ok = 1'b0;
      for (int i = 0; i < k; i++) if (!b[pidx(i, k)]) ok = 1'b0;
      if (ok && !found) begin
        v     = WAY_BITS'(k);
        found = 1'b1;
      end
    end
    return v;
  endfunction

  always_comb begin
    state_d      = state_q;
    flush_idx_d  = flush_idx_q;
    lru_d        = lru_q;
    rsp_valid_d  = 1'b0;
    rsp_set_d    = rsp_set_q;
    rsp_victim_d = rsp_victim_q;
    flush_done_d = 1'b0;
    op_bits      = apply_op(lru_q[lru_if.op_set], lru_if.op_code, lru_if.op_way);
    case (state_q)
      S_IDLE: begin
        if (lru_if.op_valid) begin
          lru_d[lru_if.op_set] = op_bits;
          rsp_valid_d          = 1'b1;
          rsp_set_d            = lru_if.op_set;
          rsp_victim_d         = victim_of(op_bits);
        end
        if (lru_if.flush_start) begin
          state_d     = S_FLUSH;
          flush_idx_d = '0;
        end
      end
      S_FLUSH: begin
        lru_d[flush_idx_q] = '0;
        if (flush_idx_q == SET_BITS'(SETS - 1)) begin
          state_d      = S_IDLE;
          flush_idx_d  = '0;
          flush_done_d = 1'b1;
        end else begin
          flush_idx_d = flush_idx_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      flush_idx_q  <= '0;
      for (int s = 0; s < SETS; s++) lru_q[s] <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_set_q    <= '0;
      rsp_victim_q <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_idx_q  <= flush_idx_d;
      lru_q        <= lru_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_set_q    <= rsp_set_d;
      rsp_victim_q <= rsp_victim_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign lru_if.op_ready   = (state_q == S_IDLE);
  assign lru_if.flush_busy = (state_q == S_FLUSH);
  assign lru_if.rsp_valid  = rsp_valid_q;
  assign lru_if.rsp_set    = rsp_set_q;
  assign lru_if.rsp_victim = rsp_victim_q;
  assign lru_if.flush_done = flush_done_q;
endmodule

// File: tb/tb_lru_matrix_tracker.sv
// tb/tb_lru_matrix_tracker.sv - bench for lru_matrix_tracker: 4-way/16-set directed and 8-way/2-set random against an order-list model
module tb_lru_matrix_tracker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lru_matrix_tracker_if #(.WAYS(4), .SETS(16)) if4 ();
  lru_matrix_tracker_if #(.WAYS(8), .SETS(2))  if8 ();

  lru_matrix_tracker #(.WAYS(4), .SETS(16)) u4 (.clk_i(clk), .rst_i(rst), .lru_if(if4.slave));
  lru_matrix_tracker #(.WAYS(8), .SETS(2))  u8 (.clk_i(clk), .rst_i(rst), .lru_if(if8.slave));

  int passed = 0;
  int total  = 0;

  // Model: per set, the list of ways from oldest (index 0) to newest.
  int nways [2] = '{4, 8};
  int nsets [2] = '{16, 2};
  int ord [2][16][8];
  int busy [2] = '{0, 0};
  bit exp_valid [2] = '{0, 0};
  bit exp_done [2] = '{0, 0};
  int exp_set [2] = '{0, 0};
  int exp_vic [2] = '{0, 0};
  int lit4 [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    else passed++;
  endtask

  task automatic m_clear(input int n, input int s);
    for (int k = 0; k < nways[n]; k++) ord[n][s][k] = k;
  endtask

  task automatic m_reset(input int n);
    for (int s = 0; s < nsets[n]; s++) m_clear(n, s);
    busy[n] = 0; exp_valid[n] = 0; exp_done[n] = 0; exp_set[n] = 0; exp_vic[n] = 0;
  endtask

  task automatic m_move(input int n, input int s, input int w, input bit to_mru);
    int rest [8];
    int c = 0;
    int nw = nways[n];
    for (int k = 0; k < nw; k++)
      if (ord[n][s][k] != w) begin rest[c] = ord[n][s][k]; c++; end
    if (to_mru) begin
      for (int k = 0; k < nw - 1; k++) ord[n][s][k] = rest[k];
      ord[n][s][nw-1] = w;
    end else begin
      ord[n][s][0] = w;
      for (int k = 0; k < nw - 1; k++) ord[n][s][k+1] = rest[k];
    end
  endtask

  task automatic m_step(input int n, input logic v, input logic [1:0] c, input int s,
                        input int w, input logic fs);
    exp_valid[n] = 0;
    exp_done[n]  = 0;
    if (busy[n] > 0) begin
      busy[n]--;
      if (busy[n] == 0) exp_done[n] = 1;
    end else begin
      if (v) begin
        case (c)
          2'b01: m_move(n, s, w, 1'b1);
          2'b10: m_move(n, s, w, 1'b0);
          2'b11: m_clear(n, s);
          default: ;
        endcase
        exp_valid[n] = 1; exp_set[n] = s; exp_vic[n] = ord[n][s][0];
      end
      if (fs) begin
        for (int s2 = 0; s2 < nsets[n]; s2++) m_clear(n, s2);
        busy[n] = nsets[n];
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reset(0); m_reset(1);
    end else begin
      m_step(0, if4.op_valid, if4.op_code, int'(if4.op_set), int'(if4.op_way), if4.flush_start);
      m_step(1, if8.op_valid, if8.op_code, int'(if8.op_set), int'(if8.op_way), if8.flush_start);
    end
  end

  task automatic cmp(input int n, input logic rv, input logic [31:0] rs, input logic [31:0] vic,
                     input logic rdy, input logic fb, input logic fd);
    string t;
    t = $sformatf("w%0d", nways[n]);
    chk({t, "_rsp_valid"},  rv,  exp_valid[n]);
    chk({t, "_rsp_set"},    rs,  exp_set[n]);
    chk({t, "_rsp_victim"}, vic, exp_vic[n]);
    chk({t, "_op_ready"},   rdy, busy[n] == 0);
    chk({t, "_flush_busy"}, fb,  busy[n] > 0);
    chk({t, "_flush_done"}, fd,  exp_done[n]);
    if (n == 0 && exp_valid[n] && lit4.size() > 0) begin
      int l = lit4.pop_front();
      if (l >= 0) chk("w4_literal_victim", vic, l);
    end
  endtask

  always @(negedge clk) begin
    cmp(0, if4.rsp_valid, 32'(if4.rsp_set), 32'(if4.rsp_victim), if4.op_ready, if4.flush_busy, if4.flush_done);
    cmp(1, if8.rsp_valid, 32'(if8.rsp_set), 32'(if8.rsp_victim), if8.op_ready, if8.flush_busy, if8.flush_done);
  end

  task automatic op4(input logic [1:0] c, input int s, input int w, input int lit);
    if4.op_valid = 1'b1; if4.op_code = c; if4.op_set = 4'(s); if4.op_way = 2'(w);
    lit4.push_back(lit);
    @(negedge clk);
    if4.op_valid = 1'b0;
  endtask

  initial begin
    int bc;
    int dc;
    int r;
    if4.op_valid = 0; if4.op_code = 0; if4.op_set = 0; if4.op_way = 0; if4.flush_start = 0;
    if8.op_valid = 0; if8.op_code = 0; if8.op_set = 0; if8.op_way = 0; if8.flush_start = 0;
    repeat (3) @(negedge clk);
    chk("reset_op_ready", if4.op_ready, 1);
    chk("reset_rsp_valid", if4.rsp_valid, 0);
    chk("reset_flush_busy", if4.flush_busy, 0);
    #2 rst = 1'b0;
    @(negedge clk);

    op4(2'b00, 3, 0, 0);
    op4(2'b01, 5, 0, 1); op4(2'b01, 5, 1, 2); op4(2'b01, 5, 2, 3); op4(2'b01, 5, 3, 0);
    op4(2'b00, 4, 0, 0);
    op4(2'b10, 5, 2, 2); op4(2'b01, 5, 2, 0); op4(2'b11, 5, 0, 0);
    chk("w4_set5_cleared_bits", 32'(u4.lru_q[5]), 0);
    for (int s = 0; s < 16; s++) op4(2'b01, s, 3, 0);

    if4.flush_start = 1'b1;
    @(negedge clk);
    if4.flush_start = 1'b0;
    bc = 0; dc = 0;
    if4.op_code = 2'b01; if4.op_set = 0; if4.op_way = 0;
    for (int c = 0; c < 40; c++) begin
      if (if4.flush_busy) bc++;
      if (if4.flush_done) dc++;
      if4.op_valid = (c < 16);
      @(negedge clk);
    end
    if4.op_valid = 1'b0;
    chk("w4_flush_busy_cycles", bc, 16);
    chk("w4_flush_done_pulses", dc, 1);
    for (int s = 0; s < 16; s++) op4(2'b00, s, 0, 0);

    if4.flush_start = 1'b1;
    op4(2'b01, 1, 0, 1);
    if4.flush_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("w4_busy_before_reset", if4.flush_busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_flush_busy", if4.flush_busy, 0);
    chk("rst_mid_flush_ready", if4.op_ready, 1);
    chk("rst_mid_flush_rsp_valid", if4.rsp_valid, 0);
    chk("rst_mid_flush_victim", 32'(if4.rsp_victim), 0);
    chk("rst_mid_flush_set", 32'(if4.rsp_set), 0);
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b0;
    dc = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (if4.flush_done) dc++;
    end
    chk("w4_no_done_after_reset", dc, 0);
    chk("w4_ready_after_reset", if4.op_ready, 1);
    op4(2'b00, 1, 0, 0);

    repeat (400) begin
      r = $urandom_range(0, 9);
      if8.op_valid    = ($urandom_range(0, 3) != 0);
      if8.op_code     = (r < 5) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
      if8.op_set      = 1'($urandom_range(0, 1));
      if8.op_way      = 3'($urandom_range(0, 7));
      if8.flush_start = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    if8.op_valid = 1'b0; if8.flush_start = 1'b0;
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/lru_matrix_tracker.md
# lru_matrix_tracker

Parametrised, registered LRU state store for an N-way set-associative cache; next generation of the combinational 4-way LRU bit encoder. Holds pairwise-order (matrix) LRU bits for every set, applies touch, demote and per-set clear operations, returns the resulting victim way one cycle later, and runs a multi-cycle whole-array flush. Sits beside the tag array in the cache controller; the controller issues one operation per lookup or fill and uses the returned victim on misses.

## Interface
- WAYS, 4, associativity; power of two, 2..8
- SETS, 16, number of sets; power of two, 2..1024
- SET_BITS, log2(SETS), set index width (derived)
- WAY_BITS, log2(WAYS), way index width (derived)
- PAIRS, WAYS*(WAYS-1)/2, LRU bits per set (derived)

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- op_valid  in  1  operation request
- op_ready  out  1  high when an operation is accepted this cycle
- op_code  in  2  00 query, 01 touch (make MRU), 10 demote (make LRU), 11 clear set
- op_set  in  SET_BITS  target set
- op_way  in  WAY_BITS  target way (ignored for query/clear)
- flush_start  in  1  pulse: clear every set
- rsp_valid  out  1  one-cycle pulse, response for accepted op
- rsp_set  out  SET_BITS  echo of op_set
- rsp_victim  out  WAY_BITS  LRU way of rsp_set after the op is applied
- flush_busy  out  1  flush in progress
- flush_done  out  1  one-cycle pulse when flush completes

## Operation
- Pair (i,j), i<j, enumerated i-major: for WAYS=4 (0,1)=bit0, (0,2)=1, (0,3)=2, (1,2)=3, (1,3)=4, (2,3)=5. Bit=1: way i more recent than way j.
- All-zero set state: order 0 oldest … WAYS-1 newest; victim = way 0.
- Touch w: set bit(w,j) for all j>w; clear bit(i,w) for all i<w; other bits unchanged.
- Demote w: clear bit(w,j) for all j>w; set bit(i,w) for all i<w.
- Clear set: all PAIRS bits of op_set to 0.
- Query: no state change.
- Victim v: unique way with bit(v,j)=0 for all j>v and bit(i,v)=1 for all i<v. Reachable states are always total orders, so exactly one v matches; the priority encoder picks the lowest matching index regardless.
- State held in flops (SETS x PAIRS); no RAM read latency.
- FSM: IDLE, FLUSH.
  - IDLE: op_ready=1. flush_start → FLUSH, flush index=0.
  - FLUSH: op_ready=0, flush_busy=1; one set cleared per cycle, index 0..SETS-1; after writing SETS-1 → IDLE, flush_done pulses that same edge.
  - flush_start in FLUSH: ignored, no restart.

## Timing
- Reset values: all LRU bits 0, FSM IDLE, op_ready=1, rsp_valid=0, rsp_set=0, rsp_victim=0, flush_busy=0, flush_done=0, flush index 0.
- Op accepted at edge N (op_valid & op_ready); state updated at N; rsp_valid/rsp_set/rsp_victim registered at N, valid during cycle N+1.
- Throughput one op/cycle; back-to-back ops to the same set see the prior update (no hazard, no stall).
- op_valid and flush_start in same IDLE cycle: op accepted and executed, rsp issued; FLUSH entered at the same edge; first set cleared next edge.
- Flush duration: flush_busy high exactly SETS cycles; flush_done high in the first IDLE cycle after; op_ready returns high in that cycle.
- Reset asserted mid-flush or mid-op: immediate return to reset values; pending response dropped; flush does not resume.
- op_valid while op_ready=0: ignored, no response, no state change.

## Test plan
- After reset, WAYS=4: query set 3 → rsp_valid next cycle, rsp_set=3, rsp_victim=0; op_ready=1.
- Set 5: touch 0, 1, 2 back-to-back → responses victim 1, 2, 3; then touch 3 → victim 0; query set 4 → victim 0 (other sets untouched).
- Set 5 after all touched in order 0..3: demote 2 → victim 2; touch 2 → victim 0; clear set → victim 0 and state bits all zero.
- Touch way 3 in sets 0..15, flush_start → flush_busy high 16 cycles, op_valid ignored during flush, flush_done one pulse, then query every set → victim 0.
- op_valid (touch set 1 way 0) with flush_start same cycle → rsp victim 1, then flush proceeds; reset asserted at flush cycle 5 → outputs at reset values immediately, flush_done never pulses, op_ready=1 after release.
- WAYS=8, SETS=2: random touch/demote sequence vs reference order-list model; rsp_victim matches every cycle.
